// File: rtl/snitch_icache_perf_cnt.sv
// L0 instruction-cache event counters with a single-entry read response port.
// Define SNITCH_ICACHE_PERF_SAT_EN for saturating counters; the default build wraps.

package snitch_icache_perf_pkg;
  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
  } icache_events_t;
endpackage

module snitch_icache_perf_cnt
  import snitch_icache_perf_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  icache_events_t [NR_FETCH_PORTS-1:0] events_i,
  input  logic                                enable_i,
  input  logic                                clear_i,
  input  logic                                rd_req_i,
  input  logic [2:0]                          rd_addr_i,
  output logic                                rd_gnt_o,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [CNT_W-1:0]                    rsp_data_o,
  output logic                                rsp_error_o
);

  localparam int unsigned NR_CNT = 5;
  localparam int unsigned INC_W  = $clog2(NR_FETCH_PORTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NR_CNT-1:0]            ev_bits [NR_FETCH_PORTS];
  logic [NR_CNT-1:0][CNT_W-1:0] cnt_q;
  logic [NR_CNT-1:0]            ovf_q;

  genvar gi;

  // Reorder each port's events so bit k matches counter index k.
  for (gi = 0; gi < NR_FETCH_PORTS; gi++) begin : g_port
    assign ev_bits[gi] = {events_i[gi].l0_stall, events_i[gi].l0_double_hit,
                          events_i[gi].l0_prefetch, events_i[gi].l0_hit,
                          events_i[gi].l0_miss};
  end

  for (gi = 0; gi < NR_CNT; gi++) begin : g_cnt
    logic [INC_W-1:0] inc;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;

    always_comb begin
      inc = '0;
      for (int p = 0; p < NR_FETCH_PORTS; p++) begin
        inc = inc + INC_W'(ev_bits[p][gi]);
      end
      sum = {1'b0, cnt_reg} + (CNT_W + 1)'(inc);
`ifdef SNITCH_ICACHE_PERF_SAT_EN
      cnt_next = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
`else
      cnt_next = sum[CNT_W-1:0];
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else if (clear_i) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else if (enable_i) begin
        cnt_reg <= cnt_next;
        ovf_reg <= ovf_reg | sum[CNT_W];
      end
    end

    assign cnt_q[gi] = cnt_reg;
    assign ovf_q[gi] = ovf_reg;
  end

  logic [CNT_W-1:0] rd_data;
  logic             rd_err;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    for (int k = 0; k < NR_CNT; k++) begin
      if (rd_addr_i == 3'(k)) rd_data = cnt_q[k];
    end
    if (rd_addr_i == 3'd5) rd_data = CNT_W'(ovf_q);
    if (rd_addr_i > 3'd5)  rd_err  = 1'b1;
  end

  assign rd_gnt_o = ~rsp_valid_o | rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_error_o <= 1'b0;
    end else if (rd_req_i && rd_gnt_o) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= rd_data;
      rsp_error_o <= rd_err;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
// Directed bench for snitch_icache_perf_cnt with 4 fetch ports and 8-bit counters.
module tb_snitch_icache_perf_cnt;
  import snitch_icache_perf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  icache_events_t [3:0] events;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic rd_req = 1'b0;
  logic [2:0] rd_addr = 3'd0;
  logic rd_gnt;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic rsp_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snitch_icache_perf_cnt #(.NR_FETCH_PORTS(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .events_i(events), .enable_i(enable),
    .clear_i(clear), .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_error_o(rsp_error)
  );

  task automatic set_ev(input logic [3:0] miss, input logic [3:0] hit, input logic [3:0] pf,
                        input logic [3:0] dh, input logic [3:0] st);
    for (int p = 0; p < 4; p++) begin
      events[p].l0_miss       = miss[p];
      events[p].l0_hit        = hit[p];
      events[p].l0_prefetch   = pf[p];
      events[p].l0_double_hit = dh[p];
      events[p].l0_stall      = st[p];
    end
  endtask

  // Issue one accepted read at a falling edge; returns the response seen one cycle later.
  task automatic do_read(input logic [2:0] a, output logic v, output logic [7:0] d, output logic e);
    @(negedge clk);
    rd_addr = a; rd_req = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    v = rsp_valid; d = rsp_data; e = rsp_error;
    $display("read addr=%0d valid=%0b data=%0d error=%0b", a, v, d, e);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    logic v, e; logic [7:0] d;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 8'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", rsp_data); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b exp=0", rsp_error); end
    checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt got=%0b exp=1", rd_gnt); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    do_read(3'd3, v, d, e);
    checks++; if (v !== 1'b1 || d !== 8'd0) begin errors++; $display("FAIL reset_cnt3 valid=%0b got=%0d exp=0", v, d); end
    do_read(3'd5, v, d, e);
    checks++; if (d !== 8'd0 || e !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0d err=%0b exp=0", d, e); end
  endtask

  task automatic test_hit_count();
    logic v, e; logic [7:0] d;
    @(negedge clk); enable = 1'b1; set_ev(4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    repeat (10) @(negedge clk);
    set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    do_read(3'd1, v, d, e);
    checks++; if (d !== 8'd40) begin errors++; $display("FAIL hit_count got=%0d exp=40", d); end
    do_read(3'd0, v, d, e);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL hit_miss0 got=%0d exp=0", d); end
  endtask

  task automatic test_mixed_events();
    logic v, e; logic [7:0] d;
    @(negedge clk); set_ev(4'b0101, 4'h0, 4'b0010, 4'b1000, 4'hF);
    repeat (3) @(negedge clk);
    set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    do_read(3'd0, v, d, e);
    checks++; if (d !== 8'd6) begin errors++; $display("FAIL mixed_miss got=%0d exp=6", d); end
    do_read(3'd2, v, d, e);
    checks++; if (d !== 8'd3) begin errors++; $display("FAIL mixed_prefetch got=%0d exp=3", d); end
    do_read(3'd3, v, d, e);
    checks++; if (d !== 8'd3) begin errors++; $display("FAIL mixed_dhit got=%0d exp=3", d); end
    do_read(3'd4, v, d, e);
    checks++; if (d !== 8'd12) begin errors++; $display("FAIL mixed_stall got=%0d exp=12", d); end
    do_read(3'd1, v, d, e);
    checks++; if (d !== 8'd40) begin errors++; $display("FAIL mixed_hit got=%0d exp=40", d); end
  endtask

  task automatic test_enable_off();
    logic v, e; logic [7:0] d;
    @(negedge clk); enable = 1'b0; set_ev(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
    repeat (5) @(negedge clk);
    set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'h0); enable = 1'b1;
    do_read(3'd1, v, d, e);
    checks++; if (d !== 8'd40) begin errors++; $display("FAIL disabled_hit got=%0d exp=40", d); end
    do_read(3'd0, v, d, e);
    checks++; if (d !== 8'd6) begin errors++; $display("FAIL disabled_miss got=%0d exp=6", d); end
  endtask

  task automatic test_error();
    logic v, e; logic [7:0] d;
    do_read(3'd6, v, d, e);
    checks++; if (e !== 1'b1 || d !== 8'd0) begin errors++; $display("FAIL addr6 err=%0b data=%0d exp err=1 data=0", e, d); end
    do_read(3'd7, v, d, e);
    checks++; if (e !== 1'b1 || d !== 8'd0) begin errors++; $display("FAIL addr7 err=%0b data=%0d exp err=1 data=0", e, d); end
    do_read(3'd4, v, d, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL addr4_err got=%0b exp=0", e); end
  endtask

  task automatic test_clear();
    logic v, e; logic [7:0] d;
    do_clear();
    @(negedge clk); set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    @(negedge clk); set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'b0111);
    @(negedge clk); set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // clear, three stall events and an accepted read all in the same cycle
    @(negedge clk); clear = 1'b1; set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'b1110);
    rd_addr = 3'd4; rd_req = 1'b1; rsp_ready = 1'b1;
    @(negedge clk); clear = 1'b0; rd_req = 1'b0; set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    $display("read addr=4 (clear cycle) valid=%0b data=%0d", rsp_valid, rsp_data);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd7) begin errors++; $display("FAIL clear_preval valid=%0b got=%0d exp=7", rsp_valid, rsp_data); end
    do_read(3'd4, v, d, e);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL clear_stall got=%0d exp=0", d); end
    do_read(3'd1, v, d, e);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL clear_hit got=%0d exp=0", d); end
  endtask

  task automatic test_overflow();
    logic v, e; logic [7:0] d;
    logic [7:0] exp_miss;
    @(negedge clk); set_ev(4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (63) @(negedge clk);
    set_ev(4'b0011, 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk); set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    do_read(3'd0, v, d, e);
    checks++; if (d !== 8'd254) begin errors++; $display("FAIL ovf_pre got=%0d exp=254", d); end
    do_read(3'd5, v, d, e);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL ovf_flag_pre got=%0d exp=0", d); end
    @(negedge clk); set_ev(4'b1001, 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk); set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
`ifdef SNITCH_ICACHE_PERF_SAT_EN
    exp_miss = 8'd255;
`else
    exp_miss = 8'd0;
`endif
    do_read(3'd0, v, d, e);
    checks++; if (d !== exp_miss) begin errors++; $display("FAIL ovf_miss got=%0d exp=%0d", d, exp_miss); end
    do_read(3'd5, v, d, e);
    checks++; if (d !== 8'd1) begin errors++; $display("FAIL ovf_flag got=%0d exp=1", d); end
    do_clear();
    do_read(3'd5, v, d, e);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL ovf_flag_clr got=%0d exp=0", d); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); set_ev(4'h0, 4'hF, 4'b0001, 4'h0, 4'h0);
    @(negedge clk); set_ev(4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    @(negedge clk); set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rsp_ready = 1'b0; rd_req = 1'b1; rd_addr = 3'd1;
    #1;
    checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt_idle got=%0b exp=1", rd_gnt); end
    @(negedge clk); rd_addr = 3'd2;
    $display("read addr=1 (held) valid=%0b data=%0d", rsp_valid, rsp_data);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd8) begin errors++; $display("FAIL b2b_first valid=%0b got=%0d exp=8", rsp_valid, rsp_data); end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rd_gnt !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 8'd8) begin
        errors++; $display("FAIL b2b_hold%0d gnt=%0b valid=%0b data=%0d exp gnt=0 valid=1 data=8", i, rd_gnt, rsp_valid, rsp_data);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt_ready got=%0b exp=1", rd_gnt); end
    @(negedge clk); rd_req = 1'b0;
    $display("read addr=2 (back-to-back) valid=%0b data=%0d", rsp_valid, rsp_data);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd1) begin errors++; $display("FAIL b2b_second valid=%0b got=%0d exp=1", rsp_valid, rsp_data); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0b exp=0", rsp_valid); end
  endtask

  task automatic test_async_reset();
    logic v, e; logic [7:0] d;
    @(negedge clk); set_ev(4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    rd_addr = 3'd1; rd_req = 1'b1; rsp_ready = 1'b0;
    @(negedge clk); rd_req = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd8) begin errors++; $display("FAIL ares_pending valid=%0b got=%0d exp=8", rsp_valid, rsp_data); end
    #2 rst_n = 1'b0;
    #1;
    $display("async reset valid=%0b data=%0d error=%0b gnt=%0b", rsp_valid, rsp_data, rsp_error, rd_gnt);
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'd0 || rsp_error !== 1'b0 || rd_gnt !== 1'b1) begin
      errors++; $display("FAIL ares_outputs valid=%0b data=%0d err=%0b gnt=%0b exp 0/0/0/1", rsp_valid, rsp_data, rsp_error, rd_gnt);
    end
    set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ares_no_rsp got=%0b exp=0", rsp_valid); end
    do_read(3'd1, v, d, e);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL ares_hit got=%0d exp=0", d); end
    do_read(3'd2, v, d, e);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL ares_prefetch got=%0d exp=0", d); end
  endtask

  initial begin
    set_ev(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    test_reset();
    test_hit_count();
    test_mixed_events();
    test_enable_off();
    test_error();
    test_clear();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
